// File: rtl/timer_sched_pkg.sv
// Shared types and defaults for the compare-match scheduler that sequences the
// chained 32-bit counter.
package timer_sched_pkg;

    localparam int N_CH_DEF = 4;
    localparam int CNT_W    = 32;
    localparam int PRESC_W  = 8;
    localparam int CH_IDX_W = 4;

    typedef struct packed {
        logic             armed;
        logic             periodic;
        logic [CNT_W-1:0] cmp;
        logic [CNT_W-1:0] period;
    } chan_state_t;

    typedef struct packed {
        logic [CH_IDX_W-1:0] ch;
        logic                arm;
        logic                periodic;
        logic [CNT_W-1:0]    delay;
    } cfg_req_t;

    // A zero delay would target the value already on the counter; promote it to one tick.
    function automatic logic [CNT_W-1:0] eff_delay(input logic [CNT_W-1:0] delay);
        return (delay == '0) ? CNT_W'(1) : delay;
    endfunction

endpackage

// File: rtl/timer_sched_chan.sv
// One compare channel: arm/disarm state, modular compare, periodic reload and
// sticky pending bit.
module timer_sched_chan
    import timer_sched_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_we_i,
    input  logic             cfg_arm_i,
    input  logic             cfg_periodic_i,
    input  logic [CNT_W-1:0] cfg_delay_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             irq_ack_i,
    output logic             evt_o,
    output logic             irq_pend_o
);

    chan_state_t st_q, st_d;
    logic        evt_q, evt_d;
    logic        pend_q, pend_d;
    logic        match;

    assign match = st_q.armed && (count_i == st_q.cmp);

    always_comb begin
        st_d  = st_q;
        evt_d = 1'b0;
        if (cfg_we_i) begin
            // Programming wins over a match seen in the same cycle; that event is dropped.
            st_d.armed = cfg_arm_i;
            if (cfg_arm_i) begin
                st_d.periodic = cfg_periodic_i;
                st_d.cmp      = count_i + cfg_delay_i;
                st_d.period   = cfg_delay_i;
            end
        end else if (match) begin
            evt_d = 1'b1;
            if (st_q.periodic) begin
                st_d.cmp = st_q.cmp + st_q.period;
            end else begin
                st_d.armed = 1'b0;
            end
        end
        pend_d = evt_q | (pend_q & ~irq_ack_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q   <= '0;
            evt_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            evt_q  <= evt_d;
            pend_q <= pend_d;
        end
    end

    assign evt_o      = evt_q;
    assign irq_pend_o = pend_q;

endmodule

// File: rtl/timer_sched.sv
// Compare-match scheduler: prescaled counter enable, channel programming port
// (valid/ready) and overflow flag around N_CH compare channels.
module timer_sched #(
    parameter int  N_CH    = timer_sched_pkg::N_CH_DEF,
    parameter int  PRESC_W = timer_sched_pkg::PRESC_W,
    parameter int  CNT_W   = timer_sched_pkg::CNT_W,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               run_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic               cnt_en_o,
    input  logic [CNT_W-1:0]   count_i,
    input  logic               ovf_i,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [CH_W-1:0]    cfg_ch_i,
    input  logic               cfg_arm_i,
    input  logic               cfg_periodic_i,
    input  logic [CNT_W-1:0]   cfg_delay_i,
    output logic [N_CH-1:0]    evt_o,
    output logic [N_CH-1:0]    irq_pend_o,
    input  logic [N_CH-1:0]    irq_ack_i,
    output logic               irq_o,
    output logic               ovf_pend_o,
    input  logic               ovf_ack_i
);

    import timer_sched_pkg::*;

    logic [PRESC_W-1:0] pc_q, pc_d;
    logic               en_q, en_d;
    logic               rdy_q, rdy_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               accept;
    cfg_req_t           req;

    // Handshake: a request transfers on any cycle where cfg_valid_i and cfg_ready_o
    // are both high; ready then drops for exactly one cycle. Requesters hold the
    // request fields stable while valid is high and ready is low.
    assign accept = cfg_valid_i & rdy_q;

    always_comb begin
        req.ch       = CH_IDX_W'(cfg_ch_i);
        req.arm      = cfg_arm_i;
        req.periodic = cfg_periodic_i;
        req.delay    = eff_delay(cfg_delay_i);

        pc_d = '0;
        en_d = 1'b0;
        if (run_i) begin
            if (pc_q >= presc_i) begin
                en_d = 1'b1;
            end else begin
                pc_d = pc_q + 1'b1;
            end
        end

        rdy_d      = ~accept;
        ovf_pend_d = ovf_i | (ovf_pend_q & ~ovf_ack_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= '0;
            en_q       <= 1'b0;
            rdy_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            en_q       <= en_d;
            rdy_q      <= rdy_d;
            ovf_pend_q <= ovf_pend_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        timer_sched_chan u_chan (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .cfg_we_i       (accept && (req.ch == CH_IDX_W'(g))),
            .cfg_arm_i      (req.arm),
            .cfg_periodic_i (req.periodic),
            .cfg_delay_i    (req.delay),
            .count_i        (count_i),
            .irq_ack_i      (irq_ack_i[g]),
            .evt_o          (evt_o[g]),
            .irq_pend_o     (irq_pend_o[g])
        );
    end

    assign cnt_en_o    = en_q;
    assign cfg_ready_o = rdy_q;
    assign ovf_pend_o  = ovf_pend_q;
    assign irq_o       = |irq_pend_o;

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: models the chained counter, issues channel
// programming, and scoreboards every event against hand-computed match counts.
`timescale 1ns/1ps
module tb_timer_sched;

    localparam int N_CH = 4;
    localparam int CNT_W = 32;
    localparam int W = N_CH + CNT_W;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              run_i = 1'b0;
    logic [7:0]        presc_i = '0;
    logic              cnt_en_o;
    logic [CNT_W-1:0]  count_i = '0;
    logic              ovf_i = 1'b0;
    logic              cfg_valid_i = 1'b0;
    logic              cfg_ready_o;
    logic [1:0]        cfg_ch_i = '0;
    logic              cfg_arm_i = 1'b0;
    logic              cfg_periodic_i = 1'b0;
    logic [CNT_W-1:0]  cfg_delay_i = '0;
    logic [N_CH-1:0]   evt_o;
    logic [N_CH-1:0]   irq_pend_o;
    logic [N_CH-1:0]   irq_ack_i = '0;
    logic              irq_o;
    logic              ovf_pend_o;
    logic              ovf_ack_i = 1'b0;

    logic              ld_req = 1'b0;
    logic [CNT_W-1:0]  ld_val = '0;
    logic [CNT_W-1:0]  prev_cnt = '0;
    logic [W-1:0]      exp_q[$];
    logic [W-1:0]      exp_item;
    int                n_vec = 0;
    int                n_bad = 0;

    timer_sched #(.N_CH(N_CH), .PRESC_W(8), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .run_i          (run_i),
        .presc_i        (presc_i),
        .cnt_en_o       (cnt_en_o),
        .count_i        (count_i),
        .ovf_i          (ovf_i),
        .cfg_valid_i    (cfg_valid_i),
        .cfg_ready_o    (cfg_ready_o),
        .cfg_ch_i       (cfg_ch_i),
        .cfg_arm_i      (cfg_arm_i),
        .cfg_periodic_i (cfg_periodic_i),
        .cfg_delay_i    (cfg_delay_i),
        .evt_o          (evt_o),
        .irq_pend_o     (irq_pend_o),
        .irq_ack_i      (irq_ack_i),
        .irq_o          (irq_o),
        .ovf_pend_o     (ovf_pend_o),
        .ovf_ack_i      (ovf_ack_i)
    );

    // Clock and counter model
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_req) count_i <= ld_val;
        else if (cnt_en_o) count_i <= count_i + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: each event must match the head of the expected queue, tagged with
    // the counter value that was on count_i in the cycle the match was detected.
    always @(negedge clk) begin
        if (!rst_i && evt_o != '0) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL evt_unexpected: got evt=%b after cnt=%h, none expected", evt_o, prev_cnt);
            end else begin
                exp_item = exp_q.pop_front();
                if ({evt_o, prev_cnt} !== exp_item) begin
                    n_bad++;
                    $display("FAIL evt_match: got evt=%b cnt=%h, need evt=%b cnt=%h",
                             evt_o, prev_cnt, exp_item[W-1:CNT_W], exp_item[CNT_W-1:0]);
                end
            end
        end
        prev_cnt = count_i;
    end

    // Driver tasks
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, need %h", name, got, want);
        end
    endtask

    task automatic expect_evt(input logic [N_CH-1:0] mask, input logic [CNT_W-1:0] at);
        exp_q.push_back({mask, at});
    endtask

    task automatic freeze_load(input logic [CNT_W-1:0] v);
        run_i = 1'b0;
        tick(2);
        ld_req = 1'b1;
        ld_val = v;
        tick();
        ld_req = 1'b0;
    endtask

    task automatic do_cfg(input int ch, input logic arm, input logic per, input logic [CNT_W-1:0] dly);
        int guard;
        guard = 0;
        cfg_valid_i    = 1'b1;
        cfg_ch_i       = 2'(ch);
        cfg_arm_i      = arm;
        cfg_periodic_i = per;
        cfg_delay_i    = dly;
        while (cfg_ready_o !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        chk("cfg_ready_wait", 64'(cfg_ready_o), 64'd1);
        tick();
        cfg_valid_i = 1'b0;
    endtask

    task automatic ack_irq(input logic [N_CH-1:0] m);
        irq_ack_i = m;
        tick();
        irq_ack_i = '0;
    endtask

    task automatic wait_cnt(input logic [CNT_W-1:0] v);
        int g;
        g = 0;
        while (count_i !== v && g < 200) begin
            tick();
            g++;
        end
        chk("reach_cnt", 64'(count_i), 64'(v));
    endtask

    initial begin
        int ones;
        int g;

        // Power-on reset
        tick(3);
        chk("por_outputs", 64'({cfg_ready_o, cnt_en_o, evt_o, irq_pend_o, irq_o, ovf_pend_o}), 64'd0);
        rst_i = 1'b0;
        chk("ready_at_release", 64'(cfg_ready_o), 64'd0);
        tick();
        chk("ready_rise", 64'(cfg_ready_o), 64'd1);

        // 1: asynchronous reset mid-count with ch0 armed
        presc_i = 8'd0;
        run_i   = 1'b1;
        do_cfg(0, 1'b1, 1'b0, 32'd20);
        ovf_i = 1'b1;
        tick();
        ovf_i = 1'b0;
        tick(3);
        chk("pre_rst_state", 64'({ovf_pend_o, cnt_en_o, cfg_ready_o}), 64'b111);
        #2 rst_i = 1'b1;
        #1 chk("async_rst", 64'({cfg_ready_o, cnt_en_o, evt_o, irq_pend_o, irq_o, ovf_pend_o}), 64'd0);
        tick();
        rst_i = 1'b0;
        chk("ready_after_rst", 64'(cfg_ready_o), 64'd0);
        tick();
        chk("ready_rise2", 64'(cfg_ready_o), 64'd1);
        tick(30);
        chk("no_evt_after_rst", 64'(irq_pend_o), 64'd0);

        // 2: one-shot, delay 5 from count 100
        freeze_load(32'd100);
        presc_i = 8'd0;
        expect_evt(4'b0001, 32'd105);
        do_cfg(0, 1'b1, 1'b0, 32'd5);
        run_i = 1'b1;
        tick(15);
        chk("oneshot_pend", 64'({irq_o, irq_pend_o}), 64'b10001);
        ack_irq(4'b0001);
        chk("oneshot_ack", 64'({irq_o, irq_pend_o}), 64'd0);
        tick(10);

        // 3: periodic ch1 with prescaler 3, paused at count 9
        freeze_load(32'd0);
        presc_i = 8'd3;
        expect_evt(4'b0010, 32'd4);
        expect_evt(4'b0010, 32'd8);
        expect_evt(4'b0010, 32'd12);
        do_cfg(1, 1'b1, 1'b1, 32'd4);
        run_i = 1'b1;
        tick(4);
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            ones += int'(cnt_en_o);
            tick();
        end
        chk("en_rate", 64'(ones), 64'd2);
        wait_cnt(32'd9);
        run_i = 1'b0;
        tick(20);
        chk("frozen_cnt", 64'(count_i), 64'd9);
        chk("frozen_en", 64'(cnt_en_o), 64'd0);
        run_i = 1'b1;
        wait_cnt(32'd13);
        do_cfg(1, 1'b0, 1'b0, 32'd0);
        tick(30);
        chk("periodic_pend", 64'(irq_pend_o), 64'b0010);
        ack_irq(4'b0010);

        // 4: wrap-around compare and overflow flag
        freeze_load(32'hFFFF_FFFE);
        presc_i = 8'd0;
        expect_evt(4'b0100, 32'h0000_0001);
        do_cfg(2, 1'b1, 1'b0, 32'd3);
        run_i = 1'b1;
        tick(10);
        run_i = 1'b0;
        chk("wrap_pend", 64'(irq_pend_o), 64'b0100);
        ack_irq(4'b0100);
        ovf_i = 1'b1;
        tick();
        ovf_i = 1'b0;
        chk("ovf_set", 64'(ovf_pend_o), 64'd1);
        ovf_ack_i = 1'b1;
        tick();
        ovf_ack_i = 1'b0;
        chk("ovf_clr", 64'(ovf_pend_o), 64'd0);
        ovf_i     = 1'b1;
        ovf_ack_i = 1'b1;
        tick();
        ovf_i     = 1'b0;
        ovf_ack_i = 1'b0;
        chk("ovf_set_wins", 64'(ovf_pend_o), 64'd1);
        ovf_ack_i = 1'b1;
        tick();
        ovf_ack_i = 1'b0;
        chk("ovf_clr2", 64'(ovf_pend_o), 64'd0);

        // 5: reprogram ch0 on the cycle its match is detected
        freeze_load(32'd200);
        do_cfg(0, 1'b1, 1'b0, 32'd3);
        run_i = 1'b1;
        wait_cnt(32'd203);
        expect_evt(4'b0001, 32'd213);
        do_cfg(0, 1'b1, 1'b0, 32'd10);
        tick(20);
        chk("coll_pend", 64'(irq_pend_o), 64'b0001);
        ack_irq(4'b0001);

        // 5b: event on ch3 coinciding with its acknowledge
        freeze_load(32'd300);
        expect_evt(4'b1000, 32'd304);
        do_cfg(3, 1'b1, 1'b0, 32'd4);
        run_i = 1'b1;
        g = 0;
        while (evt_o[3] !== 1'b1 && g < 50) begin
            tick();
            g++;
        end
        chk("evt3_seen", 64'(evt_o[3]), 64'd1);
        irq_ack_i = 4'b1000;
        tick();
        irq_ack_i = '0;
        chk("set_beats_ack", 64'(irq_pend_o), 64'b1000);
        ack_irq(4'b1000);
        chk("ch3_cleared", 64'(irq_pend_o), 64'd0);

        // 5c: two channels matching on the same count
        freeze_load(32'd400);
        expect_evt(4'b1001, 32'd406);
        do_cfg(0, 1'b1, 1'b0, 32'd6);
        do_cfg(3, 1'b1, 1'b0, 32'd6);
        run_i = 1'b1;
        tick(15);
        chk("dual_pend", 64'({irq_o, irq_pend_o}), 64'b11001);
        ack_irq(4'b1001);

        // 6: back-to-back requests, one-cycle turnaround, delay 0 as 1
        freeze_load(32'd500);
        chk("hs_c0_ready", 64'(cfg_ready_o), 64'd1);
        cfg_valid_i    = 1'b1;
        cfg_ch_i       = 2'd1;
        cfg_arm_i      = 1'b1;
        cfg_periodic_i = 1'b0;
        cfg_delay_i    = 32'd0;
        expect_evt(4'b0010, 32'd501);
        tick();
        chk("hs_c1_ready", 64'(cfg_ready_o), 64'd0);
        cfg_ch_i    = 2'd2;
        cfg_delay_i = 32'd2;
        expect_evt(4'b0100, 32'd502);
        tick();
        chk("hs_c2_ready", 64'(cfg_ready_o), 64'd1);
        tick();
        cfg_valid_i = 1'b0;
        chk("hs_c3_ready", 64'(cfg_ready_o), 64'd0);
        run_i = 1'b1;
        tick(10);
        chk("hs_pend", 64'(irq_pend_o), 64'b0110);
        ack_irq(4'b0110);

        // Report
        tick(20);
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_sched.md
Name: timer_sched

Overview:
Compare-match scheduler that sequences the free-running 32-bit chained counter (four 8-bit counter macros).
- Drives the counter's enable through a programmable prescaler.
- Watches the counter value and raises per-channel one-shot or periodic events.
- Keeps sticky interrupt-pending bits per channel.
- Sits between the counter and the bus-side register block, which programs channels through a valid/ready port.

Parameters:
N_CH, 4, number of compare channels (1..16)
PRESC_W, 8, prescaler width in bits
CNT_W, 32, counter width; must match the counter datapath

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
run_i  in  1  level; counting permitted while high
presc_i  in  PRESC_W  counter advances once per (presc_i+1) cycles
cnt_en_o  out  1  to counter en_i
count_i  in  CNT_W  from counter count_o
ovf_i  in  1  from counter ovf_o
cfg_valid_i  in  1  channel programming request
cfg_ready_o  out  1  scheduler can accept a request
cfg_ch_i  in  $clog2(N_CH)  target channel
cfg_arm_i  in  1  1 = arm channel, 0 = disarm channel
cfg_periodic_i  in  1  1 = auto-reload, 0 = one-shot
cfg_delay_i  in  CNT_W  ticks until the first match; also the reload period
evt_o  out  N_CH  one-cycle match pulse per channel
irq_pend_o  out  N_CH  sticky pending bit per channel
irq_ack_i  in  N_CH  pulse; clears the matching pending bit
irq_o  out  1  OR of irq_pend_o
ovf_pend_o  out  1  sticky counter-wrap flag
ovf_ack_i  in  1  pulse; clears ovf_pend_o

Behaviour:
Reset values
- rst_i asserted, at any time, asynchronously clears all state: every channel disarmed, cnt_en_o=0, cfg_ready_o=0, evt_o=0, irq_pend_o=0, irq_o=0, ovf_pend_o=0, prescaler count=0.
- cfg_ready_o rises 1 cycle after rst_i deasserts.

Prescaler
- Registered count pc.
- While run_i=1: when pc>=presc_i, set pc<=0 and assert cnt_en_o for the next cycle; otherwise pc<=pc+1 and cnt_en_o=0.
- run_i=0: pc<=0 and cnt_en_o<=0 (registered).
- presc_i=0 gives cnt_en_o high every cycle.
- The count_i value is frozen while cnt_en_o is low.

Config handshake
- A request is accepted when cfg_valid_i and cfg_ready_o are both high.
- cfg_ready_o drops for exactly 1 cycle after each accept (one-cycle turnaround).
- Accept with arm=1:
  - d = (cfg_delay_i==0) ? 1 : cfg_delay_i.
  - cmp <= count_i + d (mod 2^CNT_W); period <= d; periodic <= cfg_periodic_i; armed <= 1.
  - All of these are valid in the next cycle.
- Accept with arm=0: armed <= 0.
- Reprogramming an armed channel replaces its configuration.
- Request fields must be stable while valid is high and ready is low.

Match
- Channel is armed and count_i==cmp -> evt_o[ch]=1 in the next cycle (1-cycle registered latency).
- Periodic channel: on a match, cmp <= cmp + period. This cannot refire while the counter is frozen unless period=2^CNT_W.
- One-shot channel: on a match, armed <= 0.
- Counter wrap is handled by modular compare; no special case.
- A compare value already passed at arm time cannot occur, because d>=1.

Collisions
- A config accept and a match on the same channel in the same cycle: the config wins and the event is suppressed.
- Different channels are independent; simultaneous events on different channels all fire.

Pending bits
- evt_o[ch] sets irq_pend_o[ch].
- irq_ack_i[ch] clears irq_pend_o[ch]; if set and clear coincide, set wins.
- ovf_i sets ovf_pend_o and ovf_ack_i clears it, with the same priority rule.
- irq_o is registered-equivalent (OR of registers).

Decomposition:
Package timer_sched_pkg holds:
- defaults N_CH_DEF=4, CNT_W=32, PRESC_W=8;
- typedef chan_state_t = struct {armed, periodic, cmp[CNT_W], period[CNT_W]};
- typedef cfg_req_t = struct {ch, arm, periodic, delay}.

Sub-module timer_sched_chan is one compare channel: state register, match, reload and pending logic. It is instantiated N_CH times. The prescaler and handshake stay in the top.

Test Plan:
1. Reset: assert rst_i mid-count with channel 0 armed -> all outputs 0 immediately; cfg_ready_o=1 one cycle after release; no evt after release.
2. One-shot: presc_i=0, run_i=1, count_i=100, arm ch0 delay=5 one-shot -> evt_o[0] single pulse the cycle after count_i==105; irq_pend_o[0]=1 until ack; no further events.
3. Periodic plus prescaler: presc_i=3, arm ch1 delay=4 periodic at count 0 -> cnt_en_o 1-in-4 cycles; evt_o[1] after counts 4, 8, 12; stop run_i at count 9 -> no events while frozen, resumes at 12.
4. Wrap: count_i=0xFFFF_FFFE, arm ch2 delay=3 -> match at 0x0000_0001; ovf_i pulse sets ovf_pend_o; ovf_ack_i in the same cycle as ovf_i keeps it set.
5. Collision: reprogram ch0 (delay=10) in the cycle its match is detected -> no evt_o[0]; new match 10 ticks later. evt on ch3 concurrent with irq_ack_i[3] -> pending stays 1.
6. Handshake: back-to-back cfg_valid_i for 3 cycles -> accepts on cycles 0 and 2 only (ready low on 1); delay=0 behaves as delay=1.
